// File: rtl/scoreboard_issue_ctrl.sv
// Scoreboard controller for the two-FU 16-bit core (MATHER_0 ADD/SUB, MEMOREER_0 LOAD/STORE).
// Tracks each FU through issue, operand read, execute and write-back, enforcing RAW/WAR/WAW.
module scoreboard_issue_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3,
    parameter int OP_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic [REG_AW-1:0] issue_src0,
    input  logic [REG_AW-1:0] issue_src1,
    output logic              issue_ready,
    output logic              rd_start,
    output logic              rd_fu,
    output logic [REG_AW-1:0] rd_addr_0,
    output logic [REG_AW-1:0] rd_addr_1,
    input  logic [1:0]        fu_done,
    output logic [1:0]        wb_grant,
    output logic [REG_AW-1:0] wb_dest,
    output logic              wb_we,
    output logic [1:0]        busy
);
    localparam int NFU = 2;
    localparam logic [OP_W-1:0]   OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0]   OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0]   OP_LOAD  = OP_W'(2);
    localparam logic [OP_W-1:0]   OP_STORE = OP_W'(3);
    localparam logic [REG_AW-1:0] R_UNTRK  = REG_AW'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_OPS, EXEC, WAIT_WB} fu_state_e;
    // Producer tag: vld=0 means NONE, otherwise fu names the producing FU.
    typedef struct packed {
        logic vld;
        logic fu;
    } tag_t;

    fu_state_e         st_q [NFU], st_d [NFU];
    logic [OP_W-1:0]   op_q [NFU], op_d [NFU];
    logic [REG_AW-1:0] fi_q [NFU], fi_d [NFU];
    logic [REG_AW-1:0] fj_q [NFU], fj_d [NFU];
    logic [REG_AW-1:0] fk_q [NFU], fk_d [NFU];
    tag_t              qj_q [NFU], qj_d [NFU];
    tag_t              qk_q [NFU], qk_d [NFU];
    logic              rj_q [NFU], rj_d [NFU];
    logic              rk_q [NFU], rk_d [NFU];
    tag_t              res_q [NUM_REGS], res_d [NUM_REGS];

    logic [NFU-1:0] rd_elig, rd_gnt, wb_elig, wb_gnt, we_fu;
    logic           is_alu, is_mem, legal, has_dest, accept, tgt;
    tag_t           src0_tag, src1_tag;

    always_comb begin
        is_alu   = (issue_op == OP_ADD) || (issue_op == OP_SUB);
        is_mem   = (issue_op == OP_LOAD) || (issue_op == OP_STORE);
        legal    = is_alu || is_mem;
        tgt      = is_mem;
        has_dest = legal && (issue_op != OP_STORE) && (issue_dest != R_UNTRK);
        issue_ready = !rst && (!legal ||
                      ((st_q[tgt] == IDLE) && !(has_dest && res_q[issue_dest].vld)));
        accept   = issue_valid && issue_ready && legal;

        for (int i = 0; i < NFU; i++) begin
            we_fu[i]   = (op_q[i] != OP_STORE) && (fi_q[i] != R_UNTRK);
            rd_elig[i] = (st_q[i] == WAIT_OPS) && rj_q[i] && rk_q[i];
            // WAR: hold while the other FU still has to read our destination.
            wb_elig[i] = (st_q[i] == WAIT_WB) && (!we_fu[i] ||
                         ((fj_q[1-i] != fi_q[i] || !rj_q[1-i]) &&
                          (fk_q[1-i] != fi_q[i] || !rk_q[1-i])));
        end
        rd_gnt = {rd_elig[1] && !rd_elig[0], rd_elig[0]};
        wb_gnt = {wb_elig[1] && !wb_elig[0], wb_elig[0]};

        // A producer being written back this cycle is forwarded as already ready.
        src0_tag = (issue_src0 == R_UNTRK) ? tag_t'(2'b00) : res_q[issue_src0];
        if (src0_tag.vld && wb_gnt[src0_tag.fu]) src0_tag = tag_t'(2'b00);
        src1_tag = (issue_src1 == R_UNTRK) ? tag_t'(2'b00) : res_q[issue_src1];
        if (src1_tag.vld && wb_gnt[src1_tag.fu]) src1_tag = tag_t'(2'b00);

        st_d = st_q;  op_d = op_q;  fi_d = fi_q;  fj_d = fj_q;  fk_d = fk_q;
        qj_d = qj_q;  qk_d = qk_q;  rj_d = rj_q;  rk_d = rk_q;  res_d = res_q;

        for (int i = 0; i < NFU; i++) begin
            if (rd_gnt[i]) begin
                st_d[i] = EXEC;
                rj_d[i] = 1'b0;
                rk_d[i] = 1'b0;
            end
            if (st_q[i] == EXEC && fu_done[i]) st_d[i] = WAIT_WB;
            if (wb_gnt[i]) begin
                st_d[i] = IDLE;
                if (we_fu[i]) res_d[fi_q[i]] = tag_t'(2'b00);
                for (int f = 0; f < NFU; f++) begin
                    if (qj_q[f].vld && qj_q[f].fu == 1'(i)) begin
                        rj_d[f] = 1'b1;
                        qj_d[f] = tag_t'(2'b00);
                    end
                    if (qk_q[f].vld && qk_q[f].fu == 1'(i)) begin
                        rk_d[f] = 1'b1;
                        qk_d[f] = tag_t'(2'b00);
                    end
                end
            end
        end

        if (accept) begin
            st_d[tgt] = WAIT_OPS;
            op_d[tgt] = issue_op;
            fi_d[tgt] = has_dest ? issue_dest : R_UNTRK;
            fj_d[tgt] = issue_src0;
            fk_d[tgt] = issue_src1;
            qj_d[tgt] = src0_tag;
            qk_d[tgt] = src1_tag;
            rj_d[tgt] = !src0_tag.vld;
            rk_d[tgt] = !src1_tag.vld;
            if (has_dest) res_d[issue_dest] = '{vld: 1'b1, fu: tgt};
        end

        for (int i = 0; i < NFU; i++) busy[i] = (st_q[i] != IDLE);
        rd_start  = |rd_gnt;
        rd_fu     = rd_gnt[1];
        rd_addr_0 = rd_gnt[0] ? fj_q[0] : (rd_gnt[1] ? fj_q[1] : '0);
        rd_addr_1 = rd_gnt[0] ? fk_q[0] : (rd_gnt[1] ? fk_q[1] : '0);
        wb_grant  = wb_gnt;
        wb_dest   = wb_gnt[0] ? fi_q[0] : (wb_gnt[1] ? fi_q[1] : '0);
        wb_we     = |(wb_gnt & we_fu);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NFU; i++) begin
                st_q[i] <= IDLE;
                op_q[i] <= '0;
                fi_q[i] <= '0;
                fj_q[i] <= '0;
                fk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
                rj_q[i] <= 1'b0;
                rk_q[i] <= 1'b0;
            end
            for (int r = 0; r < NUM_REGS; r++) res_q[r] <= '0;
        end else begin
            st_q  <= st_d;
            op_q  <= op_d;
            fi_q  <= fi_d;
            fj_q  <= fj_d;
            fk_q  <= fk_d;
            qj_q  <= qj_d;
            qk_q  <= qk_d;
            rj_q  <= rj_d;
            rk_q  <= rk_d;
            res_q <= res_d;
        end
    end
endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Bench for scoreboard_issue_ctrl: expected reads/write-backs queued at issue, popped by a
// negedge monitor; latency and hazard timing checked against the cycles the monitor records.
module tb_scoreboard_issue_ctrl;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, LOAD = 4'd2, STORE = 4'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [3:0] issue_op;
    logic [2:0] issue_dest, issue_src0, issue_src1;
    logic       issue_ready, rd_start, rd_fu, wb_we;
    logic [2:0] rd_addr_0, rd_addr_1, wb_dest;
    logic [1:0] fu_done, wb_grant, busy;

    scoreboard_issue_ctrl #(.NUM_REGS(8), .REG_AW(3), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_dest(issue_dest),
        .issue_src0(issue_src0), .issue_src1(issue_src1), .issue_ready(issue_ready),
        .rd_start(rd_start), .rd_fu(rd_fu), .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .fu_done(fu_done), .wb_grant(wb_grant), .wb_dest(wb_dest), .wb_we(wb_we),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fu;
        logic [2:0] a;
        logic [2:0] b;
    } ev_t;

    ev_t rd_q[$];
    ev_t wb_q[$];
    int  total = 0, bad = 0;
    int  cyc = 0;
    int  rd_cyc[2] = '{-1, -1};
    int  wb_cyc[2] = '{-1, -1};
    int  wb_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rd_start) begin
            rd_cyc[rd_fu] = cyc;
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = rd_q.pop_front();
                chk("rd_fu", rd_fu, e.fu);
                chk("rd_addr_0", rd_addr_0, e.a);
                chk("rd_addr_1", rd_addr_1, e.b);
            end
        end
        if (wb_grant != 2'b00) begin
            wb_cnt++;
            wb_cyc[wb_grant[1]] = cyc;
            chk("wb_onehot", $countones(wb_grant), 1);
            if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
            else begin
                e = wb_q.pop_front();
                chk("wb_fu", wb_grant[1], e.fu);
                chk("wb_we", wb_we, e.b[0]);
                if (e.b[0]) chk("wb_dest", wb_dest, e.a);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m);
        fu_done = m;
        @(posedge clk);
        #1;
        fu_done = 2'b00;
    endtask

    // Present an instruction until accepted; t = accept cycle, n = cycles stalled.
    task automatic do_issue(input logic [3:0] op, input logic [2:0] d, s0, s1,
                            output int t, output int n);
        logic fu, we;
        n = 0;
        issue_valid = 1'b1; issue_op = op; issue_dest = d; issue_src0 = s0; issue_src1 = s1;
        @(negedge clk);
        while (!issue_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (n >= 50) chk("issue_timeout", n, 0);
        else begin
            fu = (op == LOAD) || (op == STORE);
            we = (op != STORE) && (d != 3'd7);
            rd_q.push_back('{fu: fu, a: s0, b: s1});
            wb_q.push_back('{fu: fu, a: d, b: {2'b00, we}});
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    // Second instruction must wait for MATHER's write-back, then issue one cycle later.
    task automatic stall_case(input string tag, input logic [3:0] op2, input logic [2:0] d2,
                              input logic fu2);
        int t0, n0, t1, n1;
        do_issue(ADD, 3'd1, 3'd2, 3'd3, t0, n0);
        fork
            do_issue(op2, d2, 3'd0, 3'd0, t1, n1);
            begin step(2); pulse(2'b01); end
        join
        chk({tag, "_issue_after_wb"}, t1, wb_cyc[0] + 1);
        chk({tag, "_stall_cycles"}, n1, 4);
        step(1);
        pulse(fu2 ? 2'b10 : 2'b01);
        step(3);
        chk({tag, "_second_wb"}, wb_cyc[fu2], t1 + 3);
    endtask

    initial begin
        int t, n, t0, t1, n1, cnt;
        rst = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_dest = '0;
        issue_src0 = '0; issue_src1 = '0; fu_done = 2'b00;
        step(2);
        issue_valid = 1'b1; issue_op = ADD; issue_dest = 3'd1;
        @(negedge clk);
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_wb_grant", wb_grant, 0);
        @(posedge clk); #1;
        issue_valid = 1'b0; rst = 1'b0;
        step(1);

        // basic latency
        do_issue(ADD, 3'd1, 3'd2, 3'd3, t, n);
        chk("t1_ready_now", n, 0);
        step(1); pulse(2'b01); step(2);
        chk("t1_rd_lat", rd_cyc[0], t + 1);
        chk("t1_wb_lat", wb_cyc[0], t + 3);

        // NOP and illegal opcode are accepted and discarded
        issue_valid = 1'b1; issue_op = 4'd4;
        @(negedge clk); chk("nop_ready", issue_ready, 1);
        issue_op = 4'd13;
        @(negedge clk); chk("illegal_ready", issue_ready, 1);
        @(posedge clk); #1; issue_valid = 1'b0;
        step(2);
        chk("nop_busy", busy, 0);

        // RAW
        do_issue(ADD, 3'd1, 3'd2, 3'd3, t0, n);
        do_issue(LOAD, 3'd4, 3'd1, 3'd0, t1, n1);
        chk("raw_load_issue", t1, t0 + 1);
        step(3); pulse(2'b01); step(2); pulse(2'b10); step(2);
        chk("raw_wb0", wb_cyc[0], t0 + 6);
        chk("raw_rd_after_wb", rd_cyc[1], wb_cyc[0] + 1);
        chk("raw_wb1", wb_cyc[1], t0 + 9);

        // WAW and structural
        stall_case("waw", LOAD, 3'd1, 1'b1);
        stall_case("struct", SUB, 3'd5, 1'b0);

        // both FUs reach WAIT_WB together
        do_issue(ADD, 3'd1, 3'd2, 3'd3, t0, n);
        do_issue(LOAD, 3'd4, 3'd5, 3'd6, t1, n1);
        step(1); pulse(2'b11); step(3);
        chk("tie_rd0", rd_cyc[0], t0 + 1);
        chk("tie_rd1", rd_cyc[1], t0 + 2);
        chk("tie_wb0", wb_cyc[0], t0 + 4);
        chk("tie_wb1", wb_cyc[1], t0 + 5);

        // forwarding: LOAD issued while MATHER writes its source
        do_issue(ADD, 3'd1, 3'd2, 3'd3, t0, n);
        step(1); pulse(2'b01);
        do_issue(LOAD, 3'd5, 3'd1, 3'd0, t1, n1);
        step(1); pulse(2'b10); step(2);
        chk("fwd_no_stall", n1, 0);
        chk("fwd_same_cycle", t1, wb_cyc[0]);
        chk("fwd_rd", rd_cyc[1], t1 + 1);
        chk("fwd_wb", wb_cyc[1], t1 + 3);

        // STORE writes nothing
        do_issue(STORE, 3'd2, 3'd3, 3'd4, t0, n);
        step(1); pulse(2'b10); step(2);
        chk("store_wb", wb_cyc[1], t0 + 3);

        // reset during EXEC
        do_issue(ADD, 3'd1, 3'd2, 3'd3, t0, n);
        step(1);
        rst = 1'b1;
        issue_valid = 1'b1; issue_op = ADD; issue_dest = 3'd1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", issue_ready, 0);
        chk("midrst_wb", wb_grant, 0);
        wb_q.delete();
        @(posedge clk); #1;
        issue_valid = 1'b0; rst = 1'b0;
        cnt = wb_cnt;
        pulse(2'b01); step(2);
        chk("stale_done_no_wb", wb_cnt, cnt);
        do_issue(ADD, 3'd1, 3'd2, 3'd3, t, n);
        chk("post_rst_issue_now", n, 0);
        step(1); pulse(2'b01); step(2);
        chk("post_rst_wb", wb_cyc[0], t + 3);

        chk("rd_q_empty", rd_q.size(), 0);
        chk("wb_q_empty", wb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
